// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encodings,
// captured request fields and the alignment rule.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       is_unsigned;
  } req_t;

  // Size 11 is treated as a fault together with misalignment.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: size_fault = 1'b0;
      SZ_HALF: size_fault = offset[0];
      SZ_WORD: size_fault = |offset;
      default: size_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory bus of the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [31:0]       mem_address;
  logic [31:0]       mem_wdata;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_wdata, mem_memread, mem_memwrite
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_wdata, mem_memread, mem_memwrite
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extract + sign/zero extend, and the
// store merge of a byte/halfword into the word read back from memory.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  lane_en;

  assign byte_sel = mem_word[{offset, 3'b000} +: 8];
  assign half_sel = mem_word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    load_data = mem_word;
    lane_en   = 4'b1111;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        lane_en   = 4'b0001 << offset;
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        lane_en   = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] src;
    // Store data is right-aligned, so sub-word sources repeat across lanes.
    always_comb begin
      case (size)
        SZ_BYTE: src = store_data[7:0];
        SZ_HALF: src = store_data[8*(i%2) +: 8];
        default: src = store_data[8*i +: 8];
      endcase
    end
    assign merged[8*i +: 8] = lane_en[i] ? src : mem_word[8*i +: 8];
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from the core, checks it,
// and sequences word reads, word writes or read-modify-write to data memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic clk,
  input  logic rst_n,
  load_store_unit_if.slave bus
);
  state_t            state, state_nxt;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign req_err = size_fault(bus.req_size, bus.req_addr[1:0]) ||
                   ((bus.req_addr >> 2) >= ADDR_W'(MEM_WORDS));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_rdata   = 32'h0;
    bus.resp_err     = 1'b0;
    bus.mem_memread  = 1'b0;
    bus.mem_memwrite = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                            state_nxt = RESP;
          else if (bus.req_we && bus.req_size == SZ_WORD) state_nxt = WR_ISSUE;
          else                                    state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        bus.mem_memread = 1'b1;
        state_nxt       = RD_WAIT;
      end
      RD_WAIT:  state_nxt = req_q.we ? WR_ISSUE : RESP;
      WR_ISSUE: begin
        bus.mem_memwrite = 1'b1;
        state_nxt        = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rdata_q is cleared on every acceptance so stores and errors answer 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        req_q   <= '{we: bus.req_we, size: bus.req_size, is_unsigned: bus.req_unsigned};
        addr_q  <= bus.req_addr;
        err_q   <= req_err;
        rdata_q <= '0;
        wdata_q <= bus.req_wdata;
      end
      if (state == RD_WAIT) begin
        if (req_q.we) wdata_q <= merged;
        else          rdata_q <= load_data;
      end
    end
  end

  assign bus.mem_address = 32'(addr_q >> 2);
  assign bus.mem_wdata   = wdata_q;

  lsu_lane_align u_align (
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .offset      (addr_q[1:0]),
    .mem_word    (bus.mem_rdata),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 64, number of 32-bit words in the attached data memory.
REQ-002 Parameter ADDR_W, default 32, width of core byte address and memory address.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word; 11 illegal.
REQ-009 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request rejected: misaligned, out of range or illegal size.
REQ-015 mem_address  output  32  word index (req_addr>>2) to data memory.
REQ-016 mem_wdata  output  32  word written to memory.
REQ-017 mem_memread  output  1  memory read strobe.
REQ-018 mem_memwrite  output  1  memory write strobe.
REQ-019 mem_rdata  input  32  memory read data, registered by memory one edge after a sampled memread.

Function
REQ-020 FSM states SHALL be IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Request accepted on a posedge with req_valid=1 in IDLE; address, size, we, unsigned, wdata captured into registers at that edge.
REQ-022 Error check at acceptance: size 11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr>>2 >= MEM_WORDS -> go to RESP with resp_err=1, no memory strobe ever asserted.
REQ-023 Load: IDLE -> RD_ISSUE -> RD_WAIT -> RESP -> IDLE; resp_valid high exactly 3 cycles after acceptance edge.
REQ-024 Word store: IDLE -> WR_ISSUE -> RESP; resp_valid 2 cycles after acceptance.
REQ-025 Byte/halfword store: read-modify-write IDLE -> RD_ISSUE -> RD_WAIT -> WR_ISSUE -> RESP; resp_valid 4 cycles after acceptance; only the addressed byte lanes replaced.
REQ-026 mem_memread=1 only in RD_ISSUE; mem_memwrite=1 only in WR_ISSUE; both never high together; mem_address held stable from RD_ISSUE through WR_ISSUE.
REQ-027 In RD_WAIT, mem_rdata SHALL be sampled; lane select by addr[1:0] (byte) or addr[1] (half), little-endian (lane 0 = bits 7:0).
REQ-028 Load extension: bit 7 (byte) or bit 15 (half) replicated when req_unsigned=0, zeros otherwise; word loads unmodified.
REQ-029 resp_valid SHALL be high only in RESP, one cycle; resp_rdata/resp_err valid only then, 0 otherwise; no backpressure on response.
REQ-030 req_valid while not in IDLE SHALL be ignored (not captured, not queued).
REQ-031 A new request may be accepted in the cycle after RESP (back-to-back issue through IDLE).

Reset
REQ-032 When rst_n=0 at a posedge: state -> IDLE, all outputs and captured registers -> 0, except req_ready=1 after reset.
REQ-033 Reset mid-operation SHALL abort the transaction with no response; a strobe already issued is not retracted, none further issued.

Structure
REQ-034 Shared package SHALL hold state enumeration and size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
REQ-035 One sub-module, lsu_lane_align: combinational load extract/extend and store merge; FSM stays in load_store_unit.

Verification
REQ-036 Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> mem_address=4, resp_rdata=0xDEADBEEF at 3 cycles.
REQ-037 Byte store 0xAB at 0x11 over word 0x11223344 -> memory word 0x1122AB44; signed byte load 0x11 -> 0xFFFFFFAB, unsigned -> 0x000000AB.
REQ-038 Halfword load addr 0x13 -> resp_err=1, resp_rdata=0, 1 cycle later, no memread/memwrite asserted.
REQ-039 Word load addr 0x100 (index 64, MEM_WORDS=64) -> resp_err=1, no strobe.
REQ-040 rst_n=0 during RD_WAIT of byte store -> no memwrite, no resp_valid, req_ready=1 next cycle.
REQ-041 Back-to-back requests with req_valid held high -> second accepted cycle after RESP; extra req_valid pulses during busy ignored.
